// File: rtl/spram_bus_master_if.sv
// Command/response bundle between a host and spram_bus_master.
// The host takes the master modport; the controller takes the slave modport.
interface spram_bus_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    input  cmd_ready, rd_valid, rd_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
    output cmd_ready, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/spram_bus_master.sv
// Single-port RAM controller: sequences addr/we_re and owns turnaround on the shared data bus.
// Optional write-verify readback is enabled by defining SPRAM_MASTER_READBACK_EN.
module spram_bus_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  spram_bus_master_if.slave     cmd,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we_re,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  verify_err,
  output logic                  verify_done
);

`ifdef SPRAM_MASTER_READBACK_EN
  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, VRD1, VRD2} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;
`endif

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  we_nxt;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  rvld;
  logic                  rvld_nxt;
  logic                  accept;

`ifdef SPRAM_MASTER_READBACK_EN
  logic verr;
  logic verr_nxt;
  logic vdone;
  logic vdone_nxt;

  assign verify_err  = verr;
  assign verify_done = vdone;
`else
  assign verify_err  = 1'b0;
  assign verify_done = 1'b0;
`endif

  assign cmd.cmd_ready = reset && (state == IDLE);
  assign cmd.busy      = reset && (state != IDLE);
  assign cmd.rd_valid  = rvld;
  assign cmd.rd_data   = rdata;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Drive enable is the registered we_re bit itself, so RAM and master never overlap.
  assign ram_data = ram_we_re ? wdata : {DATA_WIDTH{1'bz}};

  always_comb begin
    state_nxt = state;
    addr_nxt  = ram_addr;
    we_nxt    = 1'b0;
    wdata_nxt = wdata;
    rdata_nxt = rdata;
    rvld_nxt  = 1'b0;
`ifdef SPRAM_MASTER_READBACK_EN
    verr_nxt  = verr;
    vdone_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          addr_nxt  = cmd.cmd_addr;
          wdata_nxt = cmd.cmd_wdata;
          if (cmd.cmd_we) begin
            we_nxt    = 1'b1;
            state_nxt = WR;
          end else begin
            state_nxt = RD1;
          end
        end
      end
      WR: begin
`ifdef SPRAM_MASTER_READBACK_EN
        state_nxt = VRD1;
`else
        state_nxt = IDLE;
`endif
      end
      RD1: state_nxt = RD2;
      RD2: begin
        rdata_nxt = ram_data;
        rvld_nxt  = 1'b1;
        state_nxt = IDLE;
      end
`ifdef SPRAM_MASTER_READBACK_EN
      VRD1: state_nxt = VRD2;
      VRD2: begin
        vdone_nxt = 1'b1;
        if (ram_data != wdata) verr_nxt = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_we_re <= 1'b0;
      wdata     <= '0;
      rdata     <= '0;
      rvld      <= 1'b0;
`ifdef SPRAM_MASTER_READBACK_EN
      verr      <= 1'b0;
      vdone     <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      ram_addr  <= addr_nxt;
      ram_we_re <= we_nxt;
      wdata     <= wdata_nxt;
      rdata     <= rdata_nxt;
      rvld      <= rvld_nxt;
`ifdef SPRAM_MASTER_READBACK_EN
      verr      <= verr_nxt;
      vdone     <= vdone_nxt;
`endif
    end
  end

endmodule
